// File: rtl/racing_pkg.sv
// Shared constants and types for the racing game blocks.
package racing_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CAR_W    = 32;
    localparam int CAR_H    = 64;

    // Road area limits for the car's top-left pixel.
    localparam logic [9:0] ROAD_X_MIN = 10'd160;
    localparam logic [9:0] ROAD_X_MAX = 10'd448;
    localparam logic [9:0] ROAD_Y_MIN = 10'd0;
    localparam logic [9:0] ROAD_Y_MAX = 10'(SCREEN_H - CAR_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2
    } state_t;

    // One axis of movement. The range test happens before the add/subtract,
    // so the 10-bit result never wraps.
    function automatic logic [9:0] step_axis(input logic [9:0] pos,
                                             input logic       dec,
                                             input logic       inc,
                                             input logic [9:0] lo,
                                             input logic [9:0] hi,
                                             input logic [9:0] stp);
        logic [9:0] r;
        r = pos;
        if (dec && !inc) begin
            r = (pos < lo + stp) ? lo : pos - stp;
        end else if (inc && !dec) begin
            r = (pos > hi - stp) ? hi : pos + stp;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module input_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two register stages to resolve metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/player_car_ctrl.sv
// Player car position controller: per-frame movement, road clamping,
// and an idle/run/crash state machine with a timed respawn.
module player_car_ctrl
    import racing_pkg::*;
#(
    parameter logic [9:0] START_X      = 10'd305,
    parameter logic [9:0] START_Y      = 10'd405,
    parameter logic [9:0] X_MIN        = ROAD_X_MIN,
    parameter logic [9:0] X_MAX        = ROAD_X_MAX,
    parameter logic [9:0] Y_MIN        = ROAD_Y_MIN,
    parameter logic [9:0] Y_MAX        = ROAD_Y_MAX,
    parameter logic [9:0] STEP         = 10'd2,
    parameter int         CRASH_FRAMES = 60,
    parameter logic [9:0] VBLANK_ROW   = 10'd480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_row,
    input  logic [9:0] pix_col,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       game_en,
    input  logic       collision,
    output logic [9:0] car_yellowX,
    output logic [9:0] car_yellowY,
    output logic       crash_active,
    output logic       frame_tick
);

    localparam int         CNT_W    = $clog2(CRASH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRASH_FRAMES - 1);

    logic [3:0]       btn_s;
    logic             left_s, right_s, up_s, down_s;
    logic             cond, cond_q, frame_tick_q;
    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             latch_q, latch_d;
    logic             crash_q, crash_d;

    input_sync #(.W(4)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({btn_left, btn_right, btn_up, btn_down}),
        .q_o   (btn_s)
    );

    assign {left_s, right_s, up_s, down_s} = btn_s;

    // A pixel-enabled timing generator may hold this for several clocks.
    assign cond = (pix_row == VBLANK_ROW) && (pix_col == 10'd0);

    // Rising-edge detect of the vblank marker gives one tick per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cond_q       <= cond;
            frame_tick_q <= cond && !cond_q;
        end
    end

    // State, position, crash timer and collision latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            crash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            crash_q <= crash_d;
        end
    end

    // Next-state logic; game_en low beats every other event.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        crash_d = crash_q;
        if (!game_en) begin
            state_d = ST_IDLE;
            x_d     = START_X;
            y_d     = START_Y;
            cnt_d   = '0;
            latch_d = 1'b0;
            crash_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    x_d = START_X;
                    y_d = START_Y;
                    if (frame_tick_q) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (frame_tick_q) begin
                        // A collision arriving on the tick cycle itself still counts.
                        latch_d = 1'b0;
                        if (latch_q || collision) begin
                            state_d = ST_CRASH;
                            cnt_d   = '0;
                            crash_d = 1'b1;
                        end else begin
                            x_d = step_axis(x_q, left_s, right_s, X_MIN, X_MAX, STEP);
                            y_d = step_axis(y_q, up_s, down_s, Y_MIN, Y_MAX, STEP);
                        end
                    end else if (collision) begin
                        latch_d = 1'b1;
                    end
                end
                ST_CRASH: begin
                    if (frame_tick_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_RUN;
                            x_d     = START_X;
                            cnt_d   = '0;
                            latch_d = 1'b0;
                            crash_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign car_yellowX  = x_q;
    assign car_yellowY  = y_q;
    assign crash_active = crash_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_player_car_ctrl.sv
// Self-checking bench for player_car_ctrl: vector table plus scoreboard queue,
// with hand-written sequences for crash timing and frame-tick edge detection.
module tb_player_car_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pix_row, pix_col;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic       game_en, collision;
    logic [9:0] car_yellowX, car_yellowY;
    logic       crash_active, frame_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic l, r, u, d;
        logic respawn;
        int   nfr;
        int   ex, ey;
    } vec_t;

    typedef struct {
        int x, y;
        bit crash;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    always #5 clk = ~clk;

    player_car_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pix_row      (pix_row),
        .pix_col      (pix_col),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .game_en      (game_en),
        .collision    (collision),
        .car_yellowX  (car_yellowX),
        .car_yellowY  (car_yellowY),
        .crash_active (crash_active),
        .frame_tick   (frame_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic push_exp(input int x, input int y, input bit c);
        exp_t e;
        e.x = x; e.y = y; e.crash = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".x"}, int'(car_yellowX), e.x);
            chk({tag, ".y"}, int'(car_yellowY), e.y);
            chk({tag, ".crash"}, int'(crash_active), int'(e.crash));
        end
    endtask

    // Present the vblank marker for one cycle; the position moves on the
    // edge after frame_tick is high, so outputs are settled on return.
    task automatic do_frame(input bit coll_on_tick);
        pix_row = 10'd480; pix_col = 10'd0;
        step();
        pix_row = 10'd0;
        if (coll_on_tick) collision = 1'b1;
        step();
        collision = 1'b0;
        step();
    endtask

    task automatic set_btn(input logic l, input logic r, input logic u, input logic d);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        repeat (3) step();
    endtask

    task automatic respawn();
        game_en = 1'b0;
        step();
        game_en = 1'b1;
        do_frame(1'b0);
    endtask

    initial begin
        int ticks;
        //           l     r     u     d     resp  nfr  ex   ey
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3,   311, 405};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 75,  161, 405};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,   160, 405};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,   160, 405};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   305, 405};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 71,  447, 405};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,   448, 405};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,   448, 405};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5,   448, 415};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,   448, 416};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1,   448, 416};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   305, 405};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1,   305, 403};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 201, 305, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,   305, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1,   305, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   305, 405};

        reset = 1'b1; game_en = 1'b1; collision = 1'b0;
        pix_row = 10'd0; pix_col = 10'd0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        step(); step();
        reset = 1'b0;
        push_exp(305, 405, 1'b0);
        pop_check("reset");
        chk("reset.tick", int'(frame_tick), 0);

        // First tick moves IDLE to RUN without moving the car.
        do_frame(1'b0);
        push_exp(305, 405, 1'b0);
        pop_check("idle2run");

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].respawn) begin
                set_btn(1'b0, 1'b0, 1'b0, 1'b0);
                respawn();
            end else begin
                set_btn(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d);
                for (int f = 0; f < vecs[i].nfr; f++) do_frame(1'b0);
            end
            push_exp(vecs[i].ex, vecs[i].ey, 1'b0);
            pop_check($sformatf("vec%0d", i));
        end

        // Crash: mid-frame pulse, freeze for 60 ticks, re-centre X only.
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        do_frame(1'b0); do_frame(1'b0);
        push_exp(309, 405, 1'b0);
        pop_check("pre_crash");
        collision = 1'b1; step(); collision = 1'b0; step();
        push_exp(309, 405, 1'b0);
        pop_check("latched_no_move");
        do_frame(1'b0);
        push_exp(309, 405, 1'b1);
        pop_check("crash_entry");
        for (int k = 1; k <= 59; k++) begin
            if (k == 10) begin
                collision = 1'b1; step(); collision = 1'b0;
            end
            do_frame(1'b0);
            push_exp(309, 405, 1'b1);
            pop_check($sformatf("frozen%0d", k));
        end
        do_frame(1'b0);
        push_exp(305, 405, 1'b0);
        pop_check("respawn60");
        do_frame(1'b0);
        push_exp(307, 405, 1'b0);
        pop_check("move_after_crash");

        // Collision on the tick cycle itself counts for that tick.
        do_frame(1'b1);
        push_exp(307, 405, 1'b1);
        pop_check("coll_on_tick");

        // game_en low during CRASH: IDLE on the very next edge.
        game_en = 1'b0;
        step();
        push_exp(305, 405, 1'b0);
        pop_check("game_en_drop");
        game_en = 1'b1;
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(1'b0);
        push_exp(305, 405, 1'b0);
        pop_check("rerun");

        // Marker held for 4 cycles still yields a single tick.
        ticks = 0;
        pix_row = 10'd480; pix_col = 10'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (frame_tick) ticks++;
        end
        pix_row = 10'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (frame_tick) ticks++;
        end
        chk("tick_once", ticks, 1);

        // Reset mid-move overrides the pending step.
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        do_frame(1'b0);
        push_exp(307, 405, 1'b0);
        pop_check("pre_reset");
        pix_row = 10'd480; step(); pix_row = 10'd0;
        reset = 1'b1; step(); reset = 1'b0;
        push_exp(305, 405, 1'b0);
        pop_check("reset_mid_move");
        chk("reset_mid_tick", int'(frame_tick), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
